// File: rtl/program_loader.sv
// program_loader: packs a big-endian byte stream into 32-bit PM writes and holds the CPU in reset until the halt word lands.
// Optional LOADER_CHECKSUM_EN: one trailing XOR checksum byte decides between RUN and ERROR.
module program_loader #(
  parameter int PM_DEPTH = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic CLK,
  input  logic RESET,
  input  logic [7:0] I_RX_DATA,
  input  logic I_RX_VALID,
  output logic O_RX_READY,
  input  logic I_RELOAD,
  output logic O_MIPS_WrPM,
  output logic [31:0] O_MIPS_WrDataPM,
  output logic O_MIPS_RESET,
  output logic [$clog2(PM_DEPTH):0] O_WORD_COUNT,
  output logic O_DONE,
  output logic O_ERROR
);
  localparam int CW = $clog2(PM_DEPTH) + 1;
`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {LOAD, RUN, ERROR, CHECK} state_t;
  localparam state_t AFTER_HALT = CHECK;
`else
  typedef enum logic [1:0] {LOAD, RUN, ERROR} state_t;
  localparam state_t AFTER_HALT = RUN;
`endif
  state_t state, state_next;
  logic [1:0] idx;
  logic [23:0] sh;
  logic [31:0] word;
  logic take, take_word, last_word, at_last, reload;
  logic ready_d, reset_d, done_d, error_d;
  assign take = I_RX_VALID & O_RX_READY;
  assign word = {sh, I_RX_DATA};
  assign at_last = O_WORD_COUNT == CW'(PM_DEPTH - 1);
  assign take_word = take & (state == LOAD) & (idx == 2'd3);
  // ready drops while the terminating word's strobe is in flight so no stray byte is swallowed
  assign last_word = take_word & ((word == HALT_WORD) | at_last);
  assign reload = I_RELOAD & ((state == RUN) | (state == ERROR));
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic got, ok;
  always_ff @(posedge CLK) begin
    if (RESET | reload) begin
      sum <= '0;
      got <= 1'b0;
      ok <= 1'b0;
    end else begin
      if (take & (state == LOAD)) sum <= sum ^ I_RX_DATA;
      got <= take & (state == CHECK);
      ok <= I_RX_DATA == sum;
    end
  end
`endif
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= LOAD;
      O_RX_READY <= 1'b1;
      O_MIPS_RESET <= 1'b1;
      O_DONE <= 1'b0;
      O_ERROR <= 1'b0;
    end else begin
      state <= state_next;
      O_RX_READY <= ready_d;
      O_MIPS_RESET <= reset_d;
      O_DONE <= done_d;
      O_ERROR <= error_d;
    end
  end
  // word count still holds the pre-write value during the strobe, so at_last marks the final slot
  always_comb begin
    state_next = state;
    if (state == LOAD)
      state_next = !O_MIPS_WrPM ? LOAD : (O_MIPS_WrDataPM == HALT_WORD) ? AFTER_HALT : at_last ? ERROR : LOAD;
`ifdef LOADER_CHECKSUM_EN
    else if (state == CHECK)
      state_next = !got ? CHECK : ok ? RUN : ERROR;
`endif
    else if (reload)
      state_next = LOAD;
  end
  always_comb begin
    ready_d = (state_next == LOAD) & !last_word;
`ifdef LOADER_CHECKSUM_EN
    if (state_next == CHECK) ready_d = !(take & (state == CHECK));
`endif
    reset_d = state_next != RUN;
    done_d = state_next == RUN;
    error_d = state_next == ERROR;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx <= '0;
      sh <= '0;
      O_MIPS_WrPM <= 1'b0;
      O_MIPS_WrDataPM <= '0;
      O_WORD_COUNT <= '0;
    end else begin
      O_MIPS_WrPM <= take_word;
      if (take_word) O_MIPS_WrDataPM <= word;
      if (take & (state == LOAD)) begin
        idx <= idx + 2'd1;
        sh <= {sh[15:0], I_RX_DATA};
      end
      if (reload) begin
        idx <= '0;
        O_WORD_COUNT <= '0;
      end else begin
        O_WORD_COUNT <= O_WORD_COUNT + CW'(O_MIPS_WrPM);
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed and random loads against a word-list/XOR reference model.
module tb_program_loader;
  localparam int DEPTH = 4;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [7:0] I_RX_DATA = '0;
  logic I_RX_VALID = 1'b0;
  logic I_RELOAD = 1'b0;
  logic O_RX_READY, O_MIPS_WrPM, O_MIPS_RESET, O_DONE, O_ERROR;
  logic [31:0] O_MIPS_WrDataPM;
  logic [$clog2(DEPTH):0] O_WORD_COUNT;
  int checks = 0;
  int errors = 0;
  logic [31:0] wq[$];

  program_loader #(.PM_DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
    .CLK(CLK), .RESET(RESET), .I_RX_DATA(I_RX_DATA), .I_RX_VALID(I_RX_VALID),
    .O_RX_READY(O_RX_READY), .I_RELOAD(I_RELOAD), .O_MIPS_WrPM(O_MIPS_WrPM),
    .O_MIPS_WrDataPM(O_MIPS_WrDataPM), .O_MIPS_RESET(O_MIPS_RESET),
    .O_WORD_COUNT(O_WORD_COUNT), .O_DONE(O_DONE), .O_ERROR(O_ERROR)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (O_MIPS_WrPM) wq.push_back(O_MIPS_WrDataPM);

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit acc = 0;
    repeat (gap) tick();
    I_RX_DATA = b;
    I_RX_VALID = 1'b1;
    for (int n = 0; n < 16 && !acc; n++) begin
      acc = O_RX_READY;
      tick();
    end
    I_RX_VALID = 1'b0;
    if (!acc) chk("rx_accept", 0, 1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("rst_ready", O_RX_READY, 1);
    chk("rst_wrpm", O_MIPS_WrPM, 0);
    chk("rst_wdata", O_MIPS_WrDataPM, 0);
    chk("rst_cpu_reset", O_MIPS_RESET, 1);
    chk("rst_count", O_WORD_COUNT, 0);
    chk("rst_done", O_DONE, 0);
    chk("rst_error", O_ERROR, 0);
  endtask

  task automatic do_reload();
    I_RELOAD = 1'b1;
    tick();
    I_RELOAD = 1'b0;
    chk("reload_cpu_reset", O_MIPS_RESET, 1);
    chk("reload_count", O_WORD_COUNT, 0);
    chk("reload_done", O_DONE, 0);
    chk("reload_error", O_ERROR, 0);
    chk("reload_ready", O_RX_READY, 1);
  endtask

  // words: full byte stream to send as words; ck < 0 sends the correct checksum, else ck[7:0]
  task automatic load(input logic [31:0] words[$], input int glo, input int ghi, input int ck);
    logic [31:0] exp[$];
    logic [7:0] x, b;
    bit halted;
    x = '0;
    halted = 0;
    wq.delete();
    foreach (words[i]) if (!halted && exp.size() < DEPTH) begin
      exp.push_back(words[i]);
      halted = words[i] == HALT;
    end
    foreach (words[i]) for (int j = 3; j >= 0; j--) begin
      b = words[i][8*j +: 8];
      x ^= b;
      send(b, $urandom_range(glo, ghi));
    end
    chk("strobe_on", O_MIPS_WrPM, 1);
    chk("strobe_data", O_MIPS_WrDataPM, exp[exp.size()-1]);
    chk("cpu_reset_at_last_write", O_MIPS_RESET, 1);
    chk("count_before", O_WORD_COUNT, exp.size() - 1);
    tick();
    chk("strobe_off", O_MIPS_WrPM, 0);
    chk("count", O_WORD_COUNT, exp.size());
    chk("pulses", wq.size(), exp.size());
    foreach (exp[i]) if (i < wq.size()) chk("wr_data", wq[i], exp[i]);
    if (!halted) begin
      chk("ovf_error", O_ERROR, 1);
      chk("ovf_ready", O_RX_READY, 0);
      chk("ovf_cpu_reset", O_MIPS_RESET, 1);
      chk("ovf_done", O_DONE, 0);
    end else begin
`ifdef LOADER_CHECKSUM_EN
      logic [7:0] ckb;
      ckb = (ck < 0) ? x : ck[7:0];
      chk("check_done", O_DONE, 0);
      chk("check_cpu_reset", O_MIPS_RESET, 1);
      chk("check_ready", O_RX_READY, 1);
      send(ckb, glo);
      tick();
      chk("ck_done", O_DONE, ckb == x);
      chk("ck_error", O_ERROR, ckb != x);
      chk("ck_cpu_reset", O_MIPS_RESET, ckb != x);
      chk("ck_ready", O_RX_READY, 0);
`else
      chk("run_done", O_DONE, 1);
      chk("run_cpu_reset", O_MIPS_RESET, 0);
      chk("run_error", O_ERROR, 0);
      chk("run_ready", O_RX_READY, 0);
`endif
    end
  endtask

  initial begin
    logic [31:0] words[$];
    logic [31:0] w;
    int n;
    do_reset();
    words.delete(); words.push_back(32'h20010005); words.push_back(HALT);
    load(words, 0, 0, -1);
    do_reload();
    load(words, 3, 3, -1);
    do_reload();
    words.delete(); words.push_back(HALT);
    load(words, 0, 0, -1);
    do_reload();
    words.delete();
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom();
      words.push_back(w == HALT ? 32'h0 : w);
    end
    load(words, 0, 1, -1);
    do_reload();
    wq.delete();
    send(8'h12, 0);
    send(8'h34, 1);
    do_reset();
    chk("partial_no_pulse", wq.size(), 0);
    words.delete(); words.push_back(32'h8C220004); words.push_back(HALT);
    load(words, 0, 0, -1);
`ifdef LOADER_CHECKSUM_EN
    words.delete(); words.push_back(32'h20010005); words.push_back(HALT);
    do_reload();
    load(words, 0, 0, 8'h24);
    do_reload();
    load(words, 0, 0, 8'h00);
`endif
    for (int it = 0; it < 12; it++) begin
      do_reload();
      n = $urandom_range(0, DEPTH);
      words.delete();
      for (int i = 0; i < n; i++) begin
        w = $urandom();
        words.push_back(w == HALT ? 32'h1 : w);
      end
      if (n < DEPTH) words.push_back(HALT);
      load(words, 0, 2, $urandom_range(0, 1) ? -1 : int'($urandom_range(0, 255)));
    end
    do_reload();
    wq.delete();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    I_RELOAD = 1'b1;
    tick();
    I_RELOAD = 1'b0;
    tick();
    chk("ign_reload_count", O_WORD_COUNT, 1);
    chk("ign_reload_ready", O_RX_READY, 1);
    chk("ign_reload_cpu_reset", O_MIPS_RESET, 1);
    for (int i = 0; i < 4; i++) send(8'hFF, 0);
    tick();
    chk("ign_reload_count_end", O_WORD_COUNT, 2);
    chk("ign_reload_pulses", wq.size(), 2);
    if (wq.size() > 0) chk("ign_reload_word", wq[0], 32'h01020304);
    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
